// File: rtl/tile_fill_dma.sv
// Tile-map fill DMA: the CPU programs a rectangle and a tile index, and the block
// issues one word write per tile into the tile memory window, optionally only during vblank.
module tile_fill_dma #(
  parameter logic [31:0] BASE_ADDR = 32'h0520_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wstrb,
  output logic [31:0] cfg_rdata,
  input  logic        vblank,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t     state;
  logic [5:0] x0, y0, wm1, hm1, tile;
  logic       vbl_only, inc_mode, done, aborted;
  logic [5:0] dx, dy, n;

  logic       cfg_acc, cfg_wr, busy, start_req, abort_req, gate_open, last, row_end;
  logic [1:0] reg_sel;
  logic [5:0] nxt_dx, nxt_dy, nxt_n, nxt_x, nxt_y, nxt_tile;

  // Accepting only when cfg_ready is low guarantees single-cycle acknowledge pulses.
  assign cfg_acc   = cfg_valid && !cfg_ready;
  assign cfg_wr    = cfg_acc && (cfg_wstrb != 4'b0000);
  assign reg_sel   = cfg_addr[3:2];
  assign busy      = (state != IDLE);
  assign start_req = cfg_wr && (reg_sel == 2'd0) && cfg_wstrb[0] && cfg_wdata[0];
  assign abort_req = cfg_wr && (reg_sel == 2'd0) && cfg_wstrb[0] && cfg_wdata[3];
  assign gate_open = !vbl_only || vblank;

  assign row_end   = (dx == wm1);
  assign last      = row_end && (dy == hm1);
  assign nxt_dx    = row_end ? 6'd0 : dx + 6'd1;
  assign nxt_dy    = row_end ? dy + 6'd1 : dy;
  assign nxt_n     = n + 6'd1;
  assign nxt_x     = x0 + nxt_dx;
  assign nxt_y     = y0 + nxt_dy;
  assign nxt_tile  = inc_mode ? tile + nxt_n : tile;

  assign m_wstrb   = {4{m_valid}};

  function automatic logic [31:0] addr_of(input logic [5:0] x, input logic [5:0] y);
    return BASE_ADDR + {18'b0, y, x, 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      cfg_rdata <= '0;
      x0        <= '0;
      y0        <= '0;
      wm1       <= '0;
      hm1       <= '0;
      tile      <= '0;
      vbl_only  <= 1'b0;
      inc_mode  <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      dx        <= '0;
      dy        <= '0;
      n         <= '0;
      m_valid   <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      cfg_ready <= cfg_acc;
      cfg_rdata <= '0;
      if (cfg_acc && !cfg_wr) begin
        case (reg_sel)
          2'd1:    cfg_rdata <= {2'b0, hm1, 2'b0, wm1, 2'b0, y0, 2'b0, x0};
          2'd2:    cfg_rdata <= {26'b0, tile};
          2'd3:    cfg_rdata <= {29'b0, aborted, done, busy};
          default: cfg_rdata <= '0;
        endcase
      end

      // Geometry is frozen while a fill is in flight.
      if (cfg_wr && !busy) begin
        if (reg_sel == 2'd1) begin
          if (cfg_wstrb[0]) x0  <= cfg_wdata[5:0];
          if (cfg_wstrb[1]) y0  <= cfg_wdata[13:8];
          if (cfg_wstrb[2]) wm1 <= cfg_wdata[21:16];
          if (cfg_wstrb[3]) hm1 <= cfg_wdata[29:24];
        end
        if (reg_sel == 2'd2 && cfg_wstrb[0]) tile <= cfg_wdata[5:0];
      end

      case (state)
        IDLE: begin
          m_valid <= 1'b0;
          if (start_req) begin
            state    <= RUN;
            vbl_only <= cfg_wdata[1];
            inc_mode <= cfg_wdata[2];
            done     <= 1'b0;
            aborted  <= 1'b0;
            dx       <= '0;
            dy       <= '0;
            n        <= '0;
            m_addr   <= addr_of(x0, y0);
            m_wdata  <= {26'b0, tile};
          end
        end
        RUN: begin
          if (m_valid) begin
            if (m_ready) begin
              if (last) begin
                m_valid <= 1'b0;
                state   <= IDLE;
                done    <= 1'b1;
              end else if (abort_req) begin
                m_valid <= 1'b0;
                state   <= IDLE;
                aborted <= 1'b1;
              end else begin
                dx      <= nxt_dx;
                dy      <= nxt_dy;
                n       <= nxt_n;
                m_addr  <= addr_of(nxt_x, nxt_y);
                m_wdata <= {26'b0, nxt_tile};
                m_valid <= gate_open;
              end
            end else if (abort_req) begin
              state <= DRAIN;
            end
          end else if (abort_req) begin
            state   <= IDLE;
            aborted <= 1'b1;
          end else if (gate_open) begin
            m_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
            aborted <= 1'b1;
          end
        end
        default: begin
          m_valid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_fill_dma.sv
// Self-checking bench for tile_fill_dma: table-driven fills with a write scoreboard,
// plus hand sequences for backpressure, vblank gating, abort and reset.
module tb_tile_fill_dma;
  localparam logic [31:0] BASE = 32'h0520_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_addr, cfg_wdata, cfg_rdata;
  logic [3:0]  cfg_wstrb;
  logic        vblank;
  logic        m_valid, m_ready;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  tile_fill_dma #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_wstrb(cfg_wstrb), .cfg_rdata(cfg_rdata),
    .vblank(vblank),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [5:0] x0, y0, wm1, hm1, tile;
    logic       inc;
    logic [31:0] first_a, last_a, last_d;
  } case_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  int          hs_count;
  logic [31:0] first_addr, last_addr, last_data;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every handshake pops and compares against the model's next write.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'b0, m_valid}, 32'd1);
        check("hold_addr", m_addr, prev_addr);
        check("hold_data", m_wdata, prev_data);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", m_addr, m_wdata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", m_addr, mon_e.addr);
          check("wr_data", m_wdata, mon_e.data);
          check("wr_strb", {28'b0, m_wstrb}, 32'hF);
        end
        if (hs_count == 0) first_addr = m_addr;
        last_addr = m_addr;
        last_data = m_wdata;
        hs_count++;
      end
      prev_stall = m_valid && !m_ready;
      prev_addr  = m_addr;
      prev_data  = m_wdata;
    end
  end

  task automatic push_expected(input logic [5:0] x0, input logic [5:0] y0,
                               input logic [5:0] wm1, input logic [5:0] hm1,
                               input logic [5:0] tile, input logic inc);
    logic [5:0] n;
    logic [5:0] x, y;
    wr_t w;
    n = 6'd0;
    for (int dy = 0; dy <= int'(hm1); dy++) begin
      for (int dx = 0; dx <= int'(wm1); dx++) begin
        x = x0 + 6'(dx);
        y = y0 + 6'(dy);
        w.addr = BASE + {18'b0, y, x, 2'b00};
        w.data = {26'b0, (inc ? tile + n : tile)};
        exp_q.push_back(w);
        n = n + 6'd1;
      end
    end
  endtask

  task automatic cfg_access(input logic [1:0] idx, input logic [31:0] wd,
                            input logic [3:0] st, output logic [31:0] rd);
    cfg_valid = 1'b1;
    cfg_addr  = {28'h0, idx, 2'b00};
    cfg_wdata = wd;
    cfg_wstrb = st;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (cfg_ready) break;
    end
    if (!cfg_ready) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout: got no cfg_ready expected ack within 8 cycles");
    end
    rd        = cfg_rdata;
    cfg_valid = 1'b0;
    cfg_wstrb = 4'b0;
  endtask

  task automatic cfg_write(input logic [1:0] idx, input logic [31:0] wd, input logic [3:0] st);
    logic [31:0] dummy;
    cfg_access(idx, wd, st, dummy);
  endtask

  task automatic cfg_read(input logic [1:0] idx, output logic [31:0] rd);
    cfg_access(idx, 32'h0, 4'b0, rd);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() == 0 && !m_valid) break;
    end
    if (exp_q.size() != 0 || m_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d writes outstanding expected 0", exp_q.size());
    end
  endtask

  function automatic logic [31:0] rect_word(input logic [5:0] x0, input logic [5:0] y0,
                                            input logic [5:0] wm1, input logic [5:0] hm1);
    return {2'b0, hm1, 2'b0, wm1, 2'b0, y0, 2'b0, x0};
  endfunction

  case_t       cases[4];
  logic [31:0] rd;
  int          cyc;
  logic        bad;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    cases[0] = '{6'd3,  6'd5,  6'd1, 6'd1, 6'd7,  1'b0, 32'h0520_050C, 32'h0520_0610, 32'd7};
    cases[1] = '{6'd63, 6'd63, 6'd1, 6'd1, 6'd0,  1'b0, 32'h0520_3FFC, 32'h0520_0000, 32'd0};
    cases[2] = '{6'd0,  6'd0,  6'd2, 6'd0, 6'd62, 1'b1, 32'h0520_0000, 32'h0520_0008, 32'd0};
    cases[3] = '{6'd10, 6'd2,  6'd0, 6'd2, 6'd33, 1'b1, 32'h0520_0228, 32'h0520_0428, 32'd35};

    resetn = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_wstrb = '0;
    vblank = 1'b0; m_ready = 1'b0; hs_count = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", {31'b0, m_valid}, 32'd0);
    check("rst_m_addr", m_addr, 32'd0);
    check("rst_m_wdata", m_wdata, 32'd0);
    check("rst_outs", {26'b0, cfg_ready, m_wstrb, |cfg_rdata}, 32'd0);
    resetn = 1'b1;
    cfg_read(2'd3, rd);
    check("rst_status", rd, 32'd0);

    foreach (cases[k]) begin
      hs_count = 0;
      exp_q.delete();
      m_ready = 1'b1;
      vblank  = 1'b0;
      cfg_write(2'd1, rect_word(cases[k].x0, cases[k].y0, cases[k].wm1, cases[k].hm1), 4'hF);
      cfg_write(2'd2, {26'b0, cases[k].tile}, 4'h1);
      push_expected(cases[k].x0, cases[k].y0, cases[k].wm1, cases[k].hm1, cases[k].tile, cases[k].inc);
      cfg_write(2'd0, {29'b0, cases[k].inc, 1'b0, 1'b1}, 4'h1);
      wait_done(cyc);
      check("fill_cycles", cyc, (int'(cases[k].wm1) + 1) * (int'(cases[k].hm1) + 1) + 1);
      check("fill_count", hs_count, (int'(cases[k].wm1) + 1) * (int'(cases[k].hm1) + 1));
      check("first_addr", first_addr, cases[k].first_a);
      check("last_addr", last_addr, cases[k].last_a);
      check("last_data", last_data, cases[k].last_d);
      check("fill_mvalid", {31'b0, m_valid}, 32'd0);
      cfg_read(2'd3, rd);
      check("fill_status", rd, 32'd2);
    end

    // Abort while nothing is pending: immediate return to idle, done cleared.
    vblank = 1'b0;
    cfg_write(2'd0, 32'h3, 4'h1);
    cfg_write(2'd0, 32'h8, 4'h1);
    check("abort_idle_mvalid", {31'b0, m_valid}, 32'd0);
    cfg_read(2'd3, rd);
    check("abort_idle_status", rd, 32'd4);

    // Backpressure on the second write of the basic fill.
    hs_count = 0;
    exp_q.delete();
    cfg_write(2'd1, rect_word(6'd3, 6'd5, 6'd1, 6'd1), 4'hF);
    cfg_write(2'd2, 32'd7, 4'h1);
    push_expected(6'd3, 6'd5, 6'd1, 6'd1, 6'd7, 1'b0);
    m_ready = 1'b0;
    cfg_write(2'd0, 32'h1, 4'h1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("bp_addr", m_addr, 32'h0520_0510);
    m_ready = 1'b1;
    wait_done(cyc);
    check("bp_count", hs_count, 4);
    cfg_read(2'd3, rd);
    check("bp_status", rd, 32'd2);

    // Vblank gating, with a RECT write while busy that must be ignored.
    hs_count = 0;
    exp_q.delete();
    cfg_write(2'd1, rect_word(6'd0, 6'd0, 6'd3, 6'd0), 4'hF);
    cfg_write(2'd2, 32'd5, 4'h1);
    push_expected(6'd0, 6'd0, 6'd3, 6'd0, 6'd5, 1'b0);
    vblank  = 1'b0;
    m_ready = 1'b0;
    cfg_write(2'd0, 32'h3, 4'h1);
    cfg_write(2'd1, rect_word(6'd9, 6'd9, 6'd0, 6'd0), 4'hF);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_valid) bad = 1'b1;
    end
    check("vbl_gated", {31'b0, bad}, 32'd0);
    vblank = 1'b1;
    @(posedge clk); #1;
    check("vbl_open", {31'b0, m_valid}, 32'd1);
    vblank  = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("vbl_drop", {31'b0, m_valid}, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (m_valid) bad = 1'b1;
    end
    check("vbl_closed", {31'b0, bad}, 32'd0);
    vblank = 1'b1;
    wait_done(cyc);
    check("vbl_count", hs_count, 4);
    vblank = 1'b0;

    // Abort with a pending request: drain it, then idle with aborted set.
    hs_count = 0;
    exp_q.delete();
    cfg_write(2'd1, rect_word(6'd0, 6'd0, 6'd3, 6'd3), 4'hF);
    cfg_write(2'd2, 32'd9, 4'h1);
    exp_q.push_back('{BASE, 32'd9});
    m_ready = 1'b0;
    cfg_write(2'd0, 32'h1, 4'h1);
    @(posedge clk); #1;
    cfg_write(2'd0, 32'h8, 4'h1);
    check("drain_valid", {31'b0, m_valid}, 32'd1);
    cfg_read(2'd3, rd);
    check("drain_status", rd, 32'd1);
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("drain_done_valid", {31'b0, m_valid}, 32'd0);
    cfg_read(2'd3, rd);
    check("abort_status", rd, 32'd4);
    check("abort_count", hs_count, 1);

    // Reset in the middle of a fill.
    hs_count = 0;
    exp_q.delete();
    m_ready = 1'b0;
    cfg_write(2'd0, 32'h1, 4'h1);
    @(posedge clk); #1;
    check("pre_rst_valid", {31'b0, m_valid}, 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'b0, m_valid}, 32'd0);
    check("mid_rst_addr", m_addr, 32'd0);
    check("mid_rst_wdata", m_wdata, 32'd0);
    check("mid_rst_strb", {28'b0, m_wstrb}, 32'd0);
    resetn = 1'b1;
    cfg_read(2'd3, rd);
    check("mid_rst_status", rd, 32'd0);
    cfg_read(2'd1, rd);
    check("mid_rst_rect", rd, 32'd0);
    cfg_write(2'd1, 32'hFFFF_FFFF, 4'b0101);
    cfg_read(2'd1, rd);
    check("rect_strobe", rd, 32'h003F_003F);
    cfg_read(2'd0, rd);
    check("ctrl_read", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
